// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: decides taken/not-taken for B-type, JAL and JALR,
// hands the target PC to fetch over a valid/ready redirect, then holds a flush window.
module branch_resolve #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       funct3,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    output logic             BrUn,
    input  logic             BrEq,
    input  logic             BrLT,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             illegal,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // redirect_valid/redirect_pc stay stable until redirect_ready is seen; br_valid outside
    // IDLE is simply not accepted and is expected to be held by the upstream stage.

    localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t          state;
    logic [FW-1:0]   flush_left;
    logic            taken;
    logic            bad_funct3;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] jalr_sum;

    assign BrUn = funct3[1];

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        jalr_sum   = rs1 + imm;
        target     = pc + imm;
        if (is_jal) begin
            taken = 1'b1;
        end else if (is_jalr) begin
            taken  = 1'b1;
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            case (funct3)
                3'b000:         taken = BrEq;
                3'b001:         taken = !BrEq;
                3'b100, 3'b110: taken = BrLT;
                3'b101, 3'b111: taken = !BrLT;
                default:        bad_funct3 = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flush_left     <= '0;
            br_ready       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            illegal        <= 1'b0;
            br_cnt         <= '0;
            taken_cnt      <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    br_ready <= 1'b1;
                    if (br_valid && br_ready) begin
                        if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
                        illegal <= bad_funct3;
                        if (taken) begin
                            if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
                            redirect_pc    <= target;
                            redirect_valid <= 1'b1;
                            br_ready       <= 1'b0;
                            state          <= REDIRECT;
                        end
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            br_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            flush      <= 1'b1;
                            flush_left <= FW'(FLUSH_CYCLES);
                            state      <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // flush_left counts the flush cycles still owed including this one
                    if (flush_left <= FW'(1)) begin
                        flush    <= 1'b0;
                        br_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        flush_left <= flush_left - 1'b1;
                    end
                end
                default: begin
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                    br_ready       <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a default instance plus one with FLUSH_CYCLES=0, CNT_W=2.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0, a_valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic        is_jal = 1'b0, is_jalr = 1'b0;
    logic [31:0] pc = '0, imm = '0, rs1 = '0;
    logic        BrEq = 1'b0, BrLT = 1'b0;
    logic        redirect_ready = 1'b0, a_ready = 1'b0;

    logic        br_ready, BrUn, redirect_valid, flush, illegal;
    logic [31:0] redirect_pc;
    logic [15:0] br_cnt, taken_cnt;

    logic        a_br_ready, a_BrUn, a_redirect_valid, a_flush, a_illegal;
    logic [31:0] a_redirect_pc;
    logic [1:0]  a_br_cnt, a_taken_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .funct3(funct3), .is_jal(is_jal), .is_jalr(is_jalr), .pc(pc), .imm(imm), .rs1(rs1),
        .BrUn(BrUn), .BrEq(BrEq), .BrLT(BrLT), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush),
        .illegal(illegal), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    branch_resolve #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(2)) dut_alt (
        .clk(clk), .rst_n(rst_n), .br_valid(a_valid), .br_ready(a_br_ready),
        .funct3(funct3), .is_jal(is_jal), .is_jalr(is_jalr), .pc(pc), .imm(imm), .rs1(rs1),
        .BrUn(a_BrUn), .BrEq(BrEq), .BrLT(BrLT), .redirect_valid(a_redirect_valid),
        .redirect_ready(a_ready), .redirect_pc(a_redirect_pc), .flush(a_flush),
        .illegal(a_illegal), .br_cnt(a_br_cnt), .taken_cnt(a_taken_cnt)
    );

    // Drive one instruction for exactly one accepting edge; outputs are sampled #1 after it.
    task automatic issue(input bit which, input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [31:0] p, input logic [31:0] i, input logic [31:0] r,
                         input logic eq, input logic lt);
        @(negedge clk);
        funct3 = f3; is_jal = jal; is_jalr = jalr; pc = p; imm = i; rs1 = r;
        BrEq = eq; BrLT = lt;
        if (which) a_valid = 1'b1; else br_valid = 1'b1;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        a_valid  = 1'b0;
    endtask

    // Accept the pending redirect, then count flush cycles until br_ready returns.
    task automatic handshake(input bit which, output int flush_seen, output int edges);
        flush_seen = 0;
        edges = 0;
        @(negedge clk);
        if (which) a_ready = 1'b1; else redirect_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            edges++;
            redirect_ready = 1'b0;
            a_ready = 1'b0;
            if (which ? a_flush : flush) flush_seen++;
            if (which ? a_br_ready : br_ready) break;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++; if (br_ready !== 1'b0) begin failures++; $display("FAIL reset_br_ready: got %b want 0", br_ready); end
        checks++; if ({redirect_valid, flush, illegal} !== 3'b000) begin failures++; $display("FAIL reset_outs: got %b want 000", {redirect_valid, flush, illegal}); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", redirect_pc); end
        checks++; if ({br_cnt, taken_cnt} !== 32'h0) begin failures++; $display("FAIL reset_cnt: got %h want 0", {br_cnt, taken_cnt}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise: got %b want 1", br_ready); end
    endtask

    task automatic test_beq;
        int fs, ed;
        issue(0, 3'b000, 0, 0, 32'h100, 32'h20, 32'h0, 1, 0);
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL beq_valid: got %b want 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h120) begin failures++; $display("FAIL beq_pc: got %h want 120", redirect_pc); end
        checks++; if (br_ready !== 1'b0) begin failures++; $display("FAIL beq_ready: got %b want 0", br_ready); end
        checks++; if (taken_cnt !== 16'd1 || br_cnt !== 16'd1) begin failures++; $display("FAIL beq_cnt: got %0d/%0d want 1/1", br_cnt, taken_cnt); end
        handshake(0, fs, ed);
        checks++; if (fs !== 2) begin failures++; $display("FAIL beq_flush_len: got %0d want 2", fs); end
        checks++; if (ed !== 3) begin failures++; $display("FAIL beq_return: got %0d edges want 3", ed); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_valid_drop: got %b want 0", redirect_valid); end
    endtask

    task automatic test_bne;
        issue(0, 3'b001, 0, 0, 32'h200, 32'h40, 32'h0, 1, 0);
        checks++; if (redirect_valid !== 1'b0 || br_ready !== 1'b1) begin failures++; $display("FAIL bne_not_taken: got valid=%b ready=%b want 0/1", redirect_valid, br_ready); end
        checks++; if (br_cnt !== 16'd2 || taken_cnt !== 16'd1) begin failures++; $display("FAIL bne_cnt: got %0d/%0d want 2/1", br_cnt, taken_cnt); end
    endtask

    task automatic test_brun_bge;
        int fs, ed;
        @(negedge clk);
        funct3 = 3'b110;
        #1;
        checks++; if (BrUn !== 1'b1) begin failures++; $display("FAIL brun_bltu: got %b want 1", BrUn); end
        funct3 = 3'b100;
        #1;
        checks++; if (BrUn !== 1'b0) begin failures++; $display("FAIL brun_blt: got %b want 0", BrUn); end
        funct3 = 3'b111;
        #1;
        checks++; if (BrUn !== 1'b1) begin failures++; $display("FAIL brun_bgeu: got %b want 1", BrUn); end
        issue(0, 3'b101, 0, 0, 32'h4000, 32'hFFFF_FFF0, 32'h0, 1, 0);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3FF0) begin failures++; $display("FAIL bge_taken: got %b %h want 1 3ff0", redirect_valid, redirect_pc); end
        handshake(0, fs, ed);
        checks++; if (br_cnt !== 16'd3 || taken_cnt !== 16'd2) begin failures++; $display("FAIL bge_cnt: got %0d/%0d want 3/2", br_cnt, taken_cnt); end
    endtask

    task automatic test_jalr_hold;
        int fs, ed;
        issue(0, 3'b000, 0, 1, 32'h8000, 32'h4, 32'h2003, 0, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            br_valid = 1'b1; is_jalr = 1'b0; funct3 = 3'b000; BrEq = 1'b1;
            @(posedge clk);
            #1;
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2006 || br_ready !== 1'b0) begin
                failures++; $display("FAIL jalr_hold%0d: got v=%b pc=%h rdy=%b want 1 2006 0", c, redirect_valid, redirect_pc, br_ready);
            end
        end
        br_valid = 1'b0;
        checks++; if (br_cnt !== 16'd4 || taken_cnt !== 16'd3) begin failures++; $display("FAIL jalr_cnt: got %0d/%0d want 4/3", br_cnt, taken_cnt); end
        handshake(0, fs, ed);
        checks++; if (fs !== 2) begin failures++; $display("FAIL jalr_flush_len: got %0d want 2", fs); end
    endtask

    task automatic test_jal_priority;
        int fs, ed;
        issue(0, 3'b010, 1, 1, 32'h10, 32'h8, 32'h1000, 0, 0);
        checks++; if (redirect_pc !== 32'h18 || illegal !== 1'b0) begin failures++; $display("FAIL jal_prio: got %h ill=%b want 18 0", redirect_pc, illegal); end
        handshake(0, fs, ed);
    endtask

    task automatic test_illegal;
        issue(0, 3'b010, 0, 0, 32'h300, 32'h8, 32'h0, 1, 1);
        checks++; if (illegal !== 1'b1 || redirect_valid !== 1'b0 || br_ready !== 1'b1) begin
            failures++; $display("FAIL illegal_pulse: got ill=%b v=%b rdy=%b want 1 0 1", illegal, redirect_valid, br_ready);
        end
        checks++; if (br_cnt !== 16'd6 || taken_cnt !== 16'd4) begin failures++; $display("FAIL illegal_cnt: got %0d/%0d want 6/4", br_cnt, taken_cnt); end
        @(posedge clk);
        #1;
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_width: got %b want 0", illegal); end
    endtask

    task automatic test_flush_zero;
        int fs, ed;
        issue(1, 3'b000, 1, 0, 32'h500, 32'h100, 32'h0, 0, 0);
        checks++; if (a_redirect_valid !== 1'b1 || a_redirect_pc !== 32'h600) begin failures++; $display("FAIL f0_redirect: got %b %h want 1 600", a_redirect_valid, a_redirect_pc); end
        handshake(1, fs, ed);
        checks++; if (fs !== 0 || ed !== 1) begin failures++; $display("FAIL f0_return: got flush=%0d edges=%0d want 0 1", fs, ed); end
        checks++; if (a_redirect_valid !== 1'b0) begin failures++; $display("FAIL f0_valid_drop: got %b want 0", a_redirect_valid); end
        checks++; if (a_br_cnt !== 2'd1 || a_taken_cnt !== 2'd1) begin failures++; $display("FAIL f0_cnt: got %0d/%0d want 1/1", a_br_cnt, a_taken_cnt); end
    endtask

    task automatic test_saturate;
        int fs, ed;
        for (int n = 0; n < 4; n++) begin
            issue(1, 3'b000, 1, 0, 32'h40 * n, 32'h4, 32'h0, 0, 0);
            handshake(1, fs, ed);
        end
        checks++; if (a_br_cnt !== 2'd3 || a_taken_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt: got %0d/%0d want 3/3", a_br_cnt, a_taken_cnt); end
    endtask

    task automatic test_reset_mid_flush;
        issue(0, 3'b000, 0, 0, 32'h100, 32'h20, 32'h0, 1, 0);
        @(negedge clk);
        redirect_ready = 1'b1;
        @(posedge clk);
        #1;
        redirect_ready = 1'b0;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL pre_reset_flush: got %b want 1", flush); end
        rst_n = 1'b0;
        #1;
        checks++; if ({flush, redirect_valid, br_ready, illegal} !== 4'b0000) begin failures++; $display("FAIL async_reset_outs: got %b want 0000", {flush, redirect_valid, br_ready, illegal}); end
        checks++; if (br_cnt !== 16'd0 || taken_cnt !== 16'd0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL async_reset_state: got %0d %0d %h want 0 0 0", br_cnt, taken_cnt, redirect_pc); end
        checks++; if (a_br_cnt !== 2'd0) begin failures++; $display("FAIL async_reset_alt: got %0d want 0", a_br_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (br_ready !== 1'b1 || flush !== 1'b0) begin failures++; $display("FAIL post_reset: got rdy=%b flush=%b want 1 0", br_ready, flush); end
    endtask

    initial begin
        test_reset;
        test_beq;
        test_bne;
        test_brun_bge;
        test_jalr_hold;
        test_jal_priority;
        test_illegal;
        test_flush_zero;
        test_saturate;
        test_reset_mid_flush;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
